// File: rtl/ddr_pkg.sv
// Shared types and default constants for the note lane bank.
// Judgement outcomes are carried as judge_t inside each lane slice.
package ddr_pkg;

  typedef enum logic [1:0] {
    J_NONE,
    J_SCORE,
    J_NEAR,
    J_MISS
  } judge_t;

  localparam int DEF_LANES         = 4;
  localparam int DEF_ROWS          = 16;
  localparam int DEF_COLS          = 16;
  localparam int DEF_LANE_W        = 4;
  localparam int DEF_NOTE_H        = 2;
  localparam int DEF_SCROLL_PERIOD = 512;

  // Smallest counter width able to hold 0..period-1 (at least one bit).
  function automatic int cnt_width(input int period);
    return (period > 2) ? $clog2(period) : 1;
  endfunction

endpackage

// File: rtl/note_lane_bank_if.sv
// Player-facing bus of the note lane bank: key levels and spawn requests in,
// pixel map and per-lane judgement pulses out.
interface note_lane_bank_if
  import ddr_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int ROWS  = DEF_ROWS,
  parameter int COLS  = DEF_COLS
);

  logic [LANES-1:0]           KEY;
  logic [LANES-1:0]           sig;
  logic [ROWS-1:0][COLS-1:0]  RedPixels;
  logic [LANES-1:0]           score;
  logic [LANES-1:0]           near;
  logic [LANES-1:0]           miss;

  // Stimulus side: drives keys and spawns, observes pixels and pulses.
  modport master (
    output KEY, sig,
    input  RedPixels, score, near, miss
  );

  // Bank side.
  modport slave (
    input  KEY, sig,
    output RedPixels, score, near, miss
  );

endinterface

// File: rtl/note_lane_slice.sv
// One note lane: slot shift register, key edge detection and judgement.
// Optional feature: define DDR_PRESS_PENALTY_EN to turn a press on an empty
// hit/near zone into a miss pulse; otherwise such a press is ignored.
module note_lane_slice
  import ddr_pkg::*;
#(
  parameter int SLOTS = DEF_ROWS / DEF_NOTE_H
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_i,
  input  logic             key_i,
  input  logic             sig_i,
  output logic [SLOTS-1:0] slots_o,
  output logic             score_o,
  output logic             near_o,
  output logic             miss_o
);

  logic [SLOTS-1:0] slots_q, slots_d;
  logic [SLOTS-1:0] kept;
  logic             key_q;
  logic             press;
  judge_t           judge;
  logic             score_q, near_q, miss_q;

  assign press = key_i & ~key_q;

  // Judge against pre-shift slots, then shift on tick, then apply spawn.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    judge = J_NONE;
    kept  = slots_q;
    if (press) begin
      if (slots_q[0]) begin
        judge   = J_SCORE;
        kept[0] = 1'b0;
      end else if (slots_q[1]) begin
        // Clearing before the shift also removes the copy a tick would move into slot 0.
        judge   = J_NEAR;
        kept[1] = 1'b0;
      end else begin
`ifdef DDR_PRESS_PENALTY_EN
        judge = J_MISS;
`else
        judge = J_NONE;
`endif
      end
    end else if (tick_i && slots_q[0]) begin
      // A press with slot 0 set always scores, so a tick miss never collides with it.
      judge = J_MISS;
    end

    slots_d = kept;
    if (tick_i) begin
      slots_d = {1'b0, kept[SLOTS-1:1]};
    end
    if (sig_i) begin
      slots_d[SLOTS-1] = 1'b1;
    end
  end

  // Lane state and registered judgement pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the slot bits are plain flops, not a memory, so they are cleared in reset to drop every live note.
      slots_q <= '0;
      key_q   <= 1'b1;
      score_q <= 1'b0;
      near_q  <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      slots_q <= slots_d;
      key_q   <= key_i;
      score_q <= (judge == J_SCORE);
      near_q  <= (judge == J_NEAR);
      miss_q  <= (judge == J_MISS);
    end
  end

  assign slots_o = slots_q;
  assign score_o = score_q;
  assign near_o  = near_q;
  assign miss_o  = miss_q;

endmodule

// File: rtl/note_lane_bank.sv
// Bank of falling-note lanes with a shared scroll tick and a pixel-map view.
// Optional feature: DDR_PRESS_PENALTY_EN (see note_lane_slice) penalises
// presses on an empty hit/near zone with a miss pulse.
module note_lane_bank
  import ddr_pkg::*;
#(
  parameter int LANES         = DEF_LANES,
  parameter int ROWS          = DEF_ROWS,
  parameter int COLS          = DEF_COLS,
  parameter int LANE_W        = DEF_LANE_W,
  parameter int NOTE_H        = DEF_NOTE_H,
  parameter int SCROLL_PERIOD = DEF_SCROLL_PERIOD
) (
  input  logic          clk,
  input  logic          RST,
  note_lane_bank_if.slave bus
);

  localparam int SLOTS = ROWS / NOTE_H;
  localparam int CNT_W = cnt_width(SCROLL_PERIOD);

  if ((ROWS % NOTE_H) != 0 || SLOTS < 2 || LANES * LANE_W > COLS || SCROLL_PERIOD < 2) begin : g_bad_cfg
    $error("note_lane_bank: illegal geometry or scroll period");
  end

  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        tick;
  logic [LANES-1:0][SLOTS-1:0] slots_w;
  logic [LANES-1:0]            score_w, near_w, miss_w;
  logic [ROWS-1:0][COLS-1:0]   pix_w;

  assign tick = (cnt_q == CNT_W'(SCROLL_PERIOD - 1));

  // Scroll counter wraps at the end of each period.
  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
  end

  // Scroll counter register.
  always_ff @(posedge clk) begin
    if (!RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    note_lane_slice #(
      .SLOTS (SLOTS)
    ) u_slice (
      .clk     (clk),
      .rst_n   (RST),
      .tick_i  (tick),
      .key_i   (bus.KEY[k]),
      .sig_i   (bus.sig[k]),
      .slots_o (slots_w[k]),
      .score_o (score_w[k]),
      .near_o  (near_w[k]),
      .miss_o  (miss_w[k])
    );
  end

  // Pixels are wired straight from slot flops; unused columns stay dark.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      if (c < LANES * LANE_W) begin : g_lit
        assign pix_w[r][c] = slots_w[c / LANE_W][r / NOTE_H];
      end else begin : g_dark
        assign pix_w[r][c] = 1'b0;
      end
    end
  end

  assign bus.RedPixels = pix_w;
  assign bus.score     = score_w;
  assign bus.near      = near_w;
  assign bus.miss      = miss_w;

endmodule

// File: tb/tb_note_lane_bank.sv
// Bench for note_lane_bank with a slot-occupancy reference model.
module tb_note_lane_bank;

  localparam int LANES  = 4;
  localparam int ROWS   = 16;
  localparam int COLS   = 16;
  localparam int LANE_W = 4;
  localparam int NOTE_H = 2;
  localparam int P      = 4;
  localparam int SLOTS  = ROWS / NOTE_H;
`ifdef DDR_PRESS_PENALTY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  typedef logic [ROWS-1:0][COLS-1:0] pix_t;
  typedef logic [LANES-1:0] lv_t;

  logic clk = 1'b0;
  logic RST;
  always #5 clk = ~clk;

  note_lane_bank_if #(.LANES(LANES), .ROWS(ROWS), .COLS(COLS)) bus ();

  note_lane_bank #(
    .LANES(LANES), .ROWS(ROWS), .COLS(COLS), .LANE_W(LANE_W),
    .NOTE_H(NOTE_H), .SCROLL_PERIOD(P)
  ) dut (
    .clk (clk),
    .RST (RST),
    .bus (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: note occupancy per lane/slot, scroll phase, last pulses.
  bit  occ [LANES][SLOTS];
  bit  kprev [LANES];
  int  phase;
  bit  m_tick;
  lv_t e_sc, e_nr, e_ms;
  lv_t seen_sc, seen_nr, seen_ms;

  task automatic model_edge(input lv_t k, input lv_t s, input logic r);
    e_sc = '0; e_nr = '0; e_ms = '0; m_tick = 1'b0;
    if (!r) begin
      phase = 0;
      for (int l = 0; l < LANES; l++) begin
        kprev[l] = 1'b1;
        for (int i = 0; i < SLOTS; i++) occ[l][i] = 1'b0;
      end
    end else begin
      m_tick = (phase == P - 1);
      phase  = (phase + 1) % P;
      for (int l = 0; l < LANES; l++) begin
        bit pr;
        pr = k[l] && !kprev[l];
        kprev[l] = k[l];
        if (pr && occ[l][0]) begin
          e_sc[l] = 1'b1; occ[l][0] = 1'b0;
        end else if (pr && occ[l][1]) begin
          e_nr[l] = 1'b1; occ[l][1] = 1'b0;
        end else if (pr) begin
          e_ms[l] = PEN;
        end
        if (m_tick) begin
          if (occ[l][0]) e_ms[l] = 1'b1;   // unreached note falls off the bottom
          for (int i = 0; i < SLOTS - 1; i++) occ[l][i] = occ[l][i+1];
          occ[l][SLOTS-1] = 1'b0;
        end
        if (s[l]) occ[l][SLOTS-1] = 1'b1;
      end
    end
  endtask

  function automatic pix_t model_pix();
    pix_t p = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (c < LANES * LANE_W) p[r][c] = occ[c / LANE_W][r / NOTE_H];
    return p;
  endfunction

  function automatic pix_t block(input int lane, input int slot);
    pix_t p = '0;
    for (int r = slot * NOTE_H; r < (slot + 1) * NOTE_H; r++)
      for (int c = lane * LANE_W; c < (lane + 1) * LANE_W; c++) p[r][c] = 1'b1;
    return p;
  endfunction

  // One clock: drive, step model at the edge, sample on the falling edge.
  task automatic cyc(input lv_t k, input lv_t s, input logic r);
    bus.KEY = k; bus.sig = s; RST = r;
    @(posedge clk);
    model_edge(k, s, r);
    @(negedge clk);
    seen_sc |= bus.score; seen_nr |= bus.near; seen_ms |= bus.miss;
  endtask

  task automatic clear_seen();
    seen_sc = '0; seen_nr = '0; seen_ms = '0;
  endtask

  task automatic do_reset();
    cyc('0, '0, 1'b0);
    cyc('0, '0, 1'b0);
    cyc('0, '0, 1'b1);
  endtask

  task automatic wait_ticks(input int n, input lv_t k);
    int seen = 0;
    while (seen < n) begin
      cyc(k, '0, 1'b1);
      if (m_tick) seen++;
    end
  endtask

  task automatic test_reset();
    cyc('0, '0, 1'b0); cyc('0, '0, 1'b0); cyc('0, '0, 1'b0);
    total++; if (bus.RedPixels !== pix_t'(0)) begin bad++; $display("FAIL reset_pix got=%h exp=0", bus.RedPixels); end
    total++; if (bus.score !== 4'b0) begin bad++; $display("FAIL reset_score got=%b exp=0000", bus.score); end
    total++; if (bus.near !== 4'b0) begin bad++; $display("FAIL reset_near got=%b exp=0000", bus.near); end
    total++; if (bus.miss !== 4'b0) begin bad++; $display("FAIL reset_miss got=%b exp=0000", bus.miss); end
  endtask

  task automatic test_spawn_scroll();
    do_reset();
    cyc('0, 4'b0010, 1'b1);
    total++; if (bus.RedPixels !== block(1, SLOTS-1)) begin bad++; $display("FAIL spawn_pix got=%h exp=%h", bus.RedPixels, block(1, SLOTS-1)); end
    clear_seen();
    wait_ticks(SLOTS - 1, '0);
    total++; if (bus.RedPixels !== block(1, 0)) begin bad++; $display("FAIL scroll_bottom got=%h exp=%h", bus.RedPixels, block(1, 0)); end
    total++; if (seen_ms !== 4'b0) begin bad++; $display("FAIL scroll_early_miss got=%b exp=0000", seen_ms); end
    wait_ticks(1, '0);
    total++; if (bus.miss !== 4'b0010) begin bad++; $display("FAIL scroll_miss got=%b exp=0010", bus.miss); end
    total++; if (bus.RedPixels !== pix_t'(0)) begin bad++; $display("FAIL scroll_gone got=%h exp=0", bus.RedPixels); end
  endtask

  task automatic test_score();
    do_reset();
    cyc('0, 4'b0001, 1'b1);
    wait_ticks(SLOTS - 1, '0);
    cyc(4'b0001, '0, 1'b1);
    total++; if (bus.score !== 4'b0001) begin bad++; $display("FAIL score_pulse got=%b exp=0001", bus.score); end
    total++; if ((bus.near | bus.miss) !== 4'b0) begin bad++; $display("FAIL score_other got=%b exp=0000", bus.near | bus.miss); end
    total++; if (bus.RedPixels !== pix_t'(0)) begin bad++; $display("FAIL score_clear got=%h exp=0", bus.RedPixels); end
    clear_seen();
    wait_ticks(2, '0);
    total++; if (seen_ms !== 4'b0) begin bad++; $display("FAIL score_nomiss got=%b exp=0000", seen_ms); end
  endtask

  task automatic test_near_on_tick();
    do_reset();
    cyc('0, 4'b0100, 1'b1);
    wait_ticks(SLOTS - 2, '0);
    while (phase != P - 1) cyc('0, '0, 1'b1);
    cyc(4'b0100, '0, 1'b1);
    total++; if (m_tick !== 1'b1) begin bad++; $display("FAIL near_align got=%b exp=1", m_tick); end
    total++; if (bus.near !== 4'b0100) begin bad++; $display("FAIL near_pulse got=%b exp=0100", bus.near); end
    total++; if ((bus.score | bus.miss) !== 4'b0) begin bad++; $display("FAIL near_other got=%b exp=0000", bus.score | bus.miss); end
    total++; if (bus.RedPixels !== pix_t'(0)) begin bad++; $display("FAIL near_clear got=%h exp=0", bus.RedPixels); end
    clear_seen();
    wait_ticks(2, '0);
    total++; if (seen_ms !== 4'b0) begin bad++; $display("FAIL near_nomiss got=%b exp=0000", seen_ms); end
  endtask

  task automatic test_empty_press();
    lv_t exp_ms;
    exp_ms = PEN ? 4'b1000 : 4'b0000;
    do_reset();
    cyc(4'b1000, '0, 1'b1);
    total++; if (bus.miss !== exp_ms) begin bad++; $display("FAIL empty_miss got=%b exp=%b", bus.miss, exp_ms); end
    total++; if ((bus.score | bus.near) !== 4'b0) begin bad++; $display("FAIL empty_other got=%b exp=0000", bus.score | bus.near); end
    cyc('0, '0, 1'b1);
  endtask

  task automatic test_held_key();
    int n_sc = 0, n_nr = 0, n_ms = 0;
    do_reset();
    cyc('0, 4'b1000, 1'b1);
    wait_ticks(SLOTS - 1, '0);
    for (int i = 0; i < 20; i++) begin
      cyc(4'b1000, '0, 1'b1);
      n_sc += int'(bus.score[3]); n_nr += int'(bus.near[3]); n_ms += int'(bus.miss[3]);
    end
    total++; if (n_sc !== 1) begin bad++; $display("FAIL held_score got=%0d exp=1", n_sc); end
    total++; if (n_nr + n_ms !== 0) begin bad++; $display("FAIL held_other got=%0d exp=0", n_nr + n_ms); end
    cyc('0, '0, 1'b1);
  endtask

  task automatic test_reset_hold();
    for (int i = 0; i < 3; i++) cyc(4'b0100, '0, 1'b0);
    clear_seen();
    for (int i = 0; i < 6; i++) cyc(4'b0100, '0, 1'b1);
    total++; if ((seen_sc | seen_nr | seen_ms) !== 4'b0) begin bad++; $display("FAIL hold_pulses got=%b exp=0000", seen_sc | seen_nr | seen_ms); end
    cyc('0, '0, 1'b1);
  endtask

  task automatic test_reset_flush();
    do_reset();
    cyc('0, 4'b1111, 1'b1);
    wait_ticks(1, '0);
    cyc('0, 4'b0001, 1'b1);
    total++; if (bus.RedPixels !== model_pix()) begin bad++; $display("FAIL flush_before got=%h exp=%h", bus.RedPixels, model_pix()); end
    clear_seen();
    cyc('0, '0, 1'b0);
    total++; if (bus.RedPixels !== pix_t'(0)) begin bad++; $display("FAIL flush_pix got=%h exp=0", bus.RedPixels); end
    wait_ticks(SLOTS + 1, '0);
    total++; if (seen_ms !== 4'b0) begin bad++; $display("FAIL flush_nomiss got=%b exp=0000", seen_ms); end
  endtask

  task automatic test_random();
    lv_t k = '0, s;
    logic r;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      for (int l = 0; l < LANES; l++) if ($urandom_range(3) == 0) k[l] = ~k[l];
      for (int l = 0; l < LANES; l++) s[l] = ($urandom_range(7) == 0);
      r = ($urandom_range(499) != 0);
      cyc(k, s, r);
      total++; if (bus.RedPixels !== model_pix()) begin bad++; $display("FAIL rnd_pix cyc=%0d got=%h exp=%h", i, bus.RedPixels, model_pix()); end
      total++; if (bus.score !== e_sc) begin bad++; $display("FAIL rnd_score cyc=%0d got=%b exp=%b", i, bus.score, e_sc); end
      total++; if (bus.near !== e_nr) begin bad++; $display("FAIL rnd_near cyc=%0d got=%b exp=%b", i, bus.near, e_nr); end
      total++; if (bus.miss !== e_ms) begin bad++; $display("FAIL rnd_miss cyc=%0d got=%b exp=%b", i, bus.miss, e_ms); end
    end
  endtask

  initial begin
    test_reset();
    test_spawn_scroll();
    test_score();
    test_near_on_tick();
    test_empty_press();
    test_held_key();
    test_reset_hold();
    test_reset_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/note_lane_bank.md
NOTE_LANE_BANK -- requirements
Module: note_lane_bank

Interface
REQ-001 Parameters SHALL be:
- LANES, 4, number of note lanes.
- ROWS, 16, display rows.
- COLS, 16, display columns.
- LANE_W, 4, columns per lane.
- NOTE_H, 2, rows per note (one slot).
- SCROLL_PERIOD, 512, clk cycles per scroll step.
REQ-002 Ports SHALL be:
- clk  input  1  system clock; single clock domain.
- RST  input  1  synchronous, active-low reset.
- KEY  input  LANES  per-lane button level, 1 = pressed, already synchronised.
- sig  input  LANES  per-lane spawn request, level-sampled each cycle.
- RedPixels  output  [ROWS][COLS]  pixel map.
- score  output  LANES  one-cycle pulse: exact hit.
- near  output  LANES  one-cycle pulse: early hit.
- miss  output  LANES  one-cycle pulse: note lost.
REQ-003 Elaboration SHALL fail unless ROWS%NOTE_H==0, ROWS/NOTE_H>=2, LANES*LANE_W<=COLS and SCROLL_PERIOD>=2.

Function
REQ-004 Each lane SHALL hold SLOTS=ROWS/NOTE_H occupancy bits; slot s covers rows s*NOTE_H..s*NOTE_H+NOTE_H-1; slot 0 is the hit zone, slot 1 the near zone, slot SLOTS-1 the spawn slot.
REQ-005 RedPixels[r][c] SHALL equal slot[r/NOTE_H] of lane c/LANE_W, wired from slot registers with no added latency; columns >= LANES*LANE_W SHALL be 0.
REQ-006 A shared counter SHALL count 0..SCROLL_PERIOD-1 and wrap; tick is asserted in the cycle the counter equals SCROLL_PERIOD-1.
REQ-007 On tick, every lane SHALL shift: slot[s] <= slot[s+1] for s < SLOTS-1 and spawn slot <= 0.
REQ-008 sig[k]=1 SHALL set lane k spawn slot, applied after any shift in the same cycle; spawning onto an occupied slot is idempotent.
REQ-009 A press SHALL be KEY[k] & ~key_q[k], where key_q is KEY registered one cycle.
REQ-010 On a press, judgement SHALL use pre-shift slots: slot0=1 -> score[k], clear slot0; else slot1=1 -> near[k], clear that note, including its shifted copy on a tick.
REQ-011 On tick, slot0=1 not cleared by a same-cycle press SHALL give miss[k].
REQ-012 score, near and miss SHALL be registered, asserted the cycle after the event, and mutually exclusive per lane per cycle.
REQ-013 Lanes SHALL be fully independent; simultaneous presses, spawns and judgements across lanes are all honoured.

Reset
REQ-014 While RST=0 at a clk edge: all slots 0, counter 0, score/near/miss 0, key_q all-ones so a key held through reset yields no press.
REQ-015 Reset mid-operation SHALL discard all notes silently, with no miss pulses.

Configuration
REQ-016 Macro DDR_PRESS_PENALTY_EN defined: a press with slot0=0 and slot1=0 SHALL give miss[k] and leave slots unchanged.
REQ-017 Macro undefined: such a press SHALL produce no pulse.

Structure
REQ-018 Package ddr_pkg SHALL hold the judge_t enum {J_NONE, J_SCORE, J_NEAR, J_MISS} and default parameter constants.
REQ-019 Sub-module note_lane_slice SHALL implement one lane: slots, edge detection and judgement. note_lane_bank SHALL instantiate LANES slices by generate, own the tick counter and build RedPixels.

Verification
Bench parameters: LANES=4, ROWS=16, NOTE_H=2, SCROLL_PERIOD=4.
REQ-020 sig[1] for 1 cycle -> RedPixels rows 14-15, cols 4-7 = 1 next cycle; after 7 ticks rows 0-1 lit; 8th tick -> miss[1] pulse, rows clear.
REQ-021 Note in lane 0 slot0, rising KEY[0] -> score[0] one cycle later, rows 0-1 cols 0-3 cleared, no miss at next tick.
REQ-022 Note in slot1, press coincident with tick -> near only, note absent from slot0 afterwards, no miss.
REQ-023 Empty-lane press: with DDR_PRESS_PENALTY_EN -> miss pulse; without -> no pulse; KEY held high 20 cycles -> exactly one judgement.
REQ-024 KEY[2] held through RST=0 for 3 cycles then RST=1 -> no pulses; RST=0 with 5 notes live -> all pixels 0, no miss.
